// File: rtl/tft_frame_feeder_pkg.sv
// -----------------------------------------------------------------------------
// tft_pkg
// Shared types and constants for the TFT frame feeder.
//   state_t   : feeder FSM states (HDR only exists with TFT_FEEDER_HEADER_EN)
//   word_t    : one serializer word, RS/DC level plus 16-bit payload
//   CMD_*     : display controller command opcodes used in the frame header
//   HDR_LEN   : number of words in the address-window header
//   hdr_word(): header word lookup by position
// -----------------------------------------------------------------------------
package tft_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;
   localparam int         HDR_LEN   = 7;

`ifdef TFT_FEEDER_HEADER_EN
   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PIX} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_PIX} state_t;
`endif

   typedef struct packed {
      logic        rs;    // 0 = command, 1 = data
      logic [15:0] data;
   } word_t;

   localparam word_t IDLE_WORD = '{rs: 1'b1, data: 16'h0000};

   // Header: column window 0..x_last, row window 0..y_last, then memory write.
   function automatic word_t hdr_word(input logic [2:0]  idx,
                                      input logic [15:0] x_last,
                                      input logic [15:0] y_last);
      case (idx)
         3'd0:    return '{rs: 1'b0, data: {8'h00, CMD_CASET}};
         3'd1:    return '{rs: 1'b1, data: 16'h0000};
         3'd2:    return '{rs: 1'b1, data: x_last};
         3'd3:    return '{rs: 1'b0, data: {8'h00, CMD_RASET}};
         3'd4:    return '{rs: 1'b1, data: 16'h0000};
         3'd5:    return '{rs: 1'b1, data: y_last};
         3'd6:    return '{rs: 1'b0, data: {8'h00, CMD_RAMWR}};
         default: return IDLE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/tft_frame_feeder_if.sv
// -----------------------------------------------------------------------------
// tft_frame_feeder_if
// Groups the two streams of the feeder:
//   pixel side : pix_valid, pix_data (RGB565) in, pix_ready out
//   word side  : word_req pulse in, word_data / word_rs out
// modport slave  : the feeder
// modport master : the environment (pixel source + SPI serializer)
// -----------------------------------------------------------------------------
interface tft_frame_feeder_if;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        pix_ready;
   logic        word_req;
   logic [15:0] word_data;
   logic        word_rs;

   modport slave  (input  pix_valid, pix_data, word_req,
                   output pix_ready, word_data, word_rs);
   modport master (output pix_valid, pix_data, word_req,
                   input  pix_ready, word_data, word_rs);
endinterface

// File: rtl/tft_pixel_fifo.sv
// -----------------------------------------------------------------------------
// tft_pixel_fifo
// Synchronous FIFO for pixels; DEPTH must be a power of two (>= 4).
//   push_i/data_i : write, ignored when full
//   pop_i/data_o  : read, data_o shows the head, pop ignored when empty
//   full_o/empty_o: derived from the occupancy counter
// -----------------------------------------------------------------------------
module tft_pixel_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // NOTE: storage has no reset; the pointers and count define validity,
   // and a resettable array would cost a reset net per bit for nothing.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/tft_frame_feeder.sv
// -----------------------------------------------------------------------------
// tft_frame_feeder
// Feeds a TFT SPI serializer: on frame_start emits an optional address-window
// header (macro TFT_FEEDER_HEADER_EN) followed by H_RES*V_RES pixel words
// popped from an internal pixel FIFO, one per word_req pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   frame_start : pulse, starts a frame (only honoured in IDLE)
//   bus         : pixel stream in, word stream out (tft_frame_feeder_if.slave)
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last pixel word is consumed
//   underrun    : sticky, a pixel word was needed while the FIFO was empty
// word_data/word_rs always show the word the next word_req will consume.
// -----------------------------------------------------------------------------
module tft_frame_feeder
   import tft_pkg::*;
#(
   parameter int H_RES      = 160,
   parameter int V_RES      = 128,
   parameter int FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   tft_frame_feeder_if.slave  bus,
   output logic               busy,
   output logic               frame_done,
   output logic               underrun
);
   localparam int TOTAL = H_RES * V_RES;
   localparam int CNT_W = ($clog2(TOTAL) > 0) ? $clog2(TOTAL) : 1;

   state_t             state_q, state_d;
   word_t              word_q, word_d;
   logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic               frame_done_q, frame_done_d;
   logic               underrun_q, underrun_d;
   logic               ready_q;
   logic               load_pix, fifo_pop, fifo_full, fifo_empty;
   logic [15:0]        fifo_data;
`ifdef TFT_FEEDER_HEADER_EN
   logic [2:0]         hdr_idx_q, hdr_idx_d;
`endif

   // ready_q keeps pix_ready low while in reset.
   assign bus.pix_ready = ready_q && !fifo_full;
   assign bus.word_data = word_q.data;
   assign bus.word_rs   = word_q.rs;
   assign busy          = (state_q != ST_IDLE);
   assign frame_done    = frame_done_q;
   assign underrun      = underrun_q;

   tft_pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (bus.pix_valid && bus.pix_ready),
      .data_i  (bus.pix_data),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // NOTE: every combinational output is defaulted first so no path through
   // the case statement leaves a signal unassigned (which would infer a latch).
   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      pix_cnt_d    = pix_cnt_q;
      frame_done_d = 1'b0;
      underrun_d   = underrun_q;
      load_pix     = 1'b0;
      fifo_pop     = 1'b0;
`ifdef TFT_FEEDER_HEADER_EN
      hdr_idx_d    = hdr_idx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               underrun_d = 1'b0;
               pix_cnt_d  = '0;
`ifdef TFT_FEEDER_HEADER_EN
               state_d    = ST_HDR;
               hdr_idx_d  = '0;
               word_d     = hdr_word(3'd0, 16'(H_RES - 1), 16'(V_RES - 1));
`else
               state_d    = ST_PIX;
               load_pix   = 1'b1;
`endif
            end
         end
`ifdef TFT_FEEDER_HEADER_EN
         ST_HDR: begin
            if (bus.word_req) begin
               if (hdr_idx_q == 3'(HDR_LEN - 1)) begin
                  state_d  = ST_PIX;
                  load_pix = 1'b1;
               end else begin
                  hdr_idx_d = hdr_idx_q + 3'd1;
                  word_d    = hdr_word(hdr_idx_q + 3'd1,
                                       16'(H_RES - 1), 16'(V_RES - 1));
               end
            end
         end
`endif
         ST_PIX: begin
            if (bus.word_req) begin
               if (pix_cnt_q == CNT_W'(TOTAL - 1)) begin
                  state_d      = ST_IDLE;
                  word_d       = IDLE_WORD;
                  pix_cnt_d    = '0;
                  frame_done_d = 1'b1;
               end else begin
                  pix_cnt_d = pix_cnt_q + CNT_W'(1);
                  load_pix  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The next pixel word is fetched as soon as the previous one is
      // consumed, so it is already on word_data when its word_req arrives.
      if (load_pix) begin
         if (fifo_empty) begin
            word_d     = '{rs: 1'b1, data: 16'h0000};
            underrun_d = 1'b1;
         end else begin
            word_d   = '{rs: 1'b1, data: fifo_data};
            fifo_pop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         word_q       <= IDLE_WORD;
         pix_cnt_q    <= '0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
         ready_q      <= 1'b0;
`ifdef TFT_FEEDER_HEADER_EN
         hdr_idx_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         pix_cnt_q    <= pix_cnt_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
         ready_q      <= 1'b1;
`ifdef TFT_FEEDER_HEADER_EN
         hdr_idx_q    <= hdr_idx_d;
`endif
      end
   end
endmodule

// File: tb/tb_tft_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_tft_frame_feeder
// Directed bench for tft_frame_feeder with H_RES=4, V_RES=2, FIFO_DEPTH=16.
// Works with and without TFT_FEEDER_HEADER_EN.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_tft_frame_feeder;
   localparam int H_RES = 4;
   localparam int V_RES = 2;
   localparam int DEPTH = 16;
   localparam int TOTAL = H_RES * V_RES;
`ifdef TFT_FEEDER_HEADER_EN
   localparam int HL = 7;
`else
   localparam int HL = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic frame_start;
   logic busy, frame_done, underrun;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   tft_frame_feeder_if bus_if ();

   tft_frame_feeder #(.H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .bus         (bus_if),
      .busy        (busy),
      .frame_done  (frame_done),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   // Header words for a 4x2 window: end column 3, end row 1.
   function automatic logic [16:0] hdr_exp(input int i);
      case (i)
         0:       return {1'b0, 16'h002A};
         1:       return {1'b1, 16'h0000};
         2:       return {1'b1, 16'h0003};
         3:       return {1'b0, 16'h002B};
         4:       return {1'b1, 16'h0000};
         5:       return {1'b1, 16'h0001};
         6:       return {1'b0, 16'h002C};
         default: return {1'b1, 16'h0000};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_px(input logic [15:0] val);
      bus_if.pix_valid = 1'b1;
      bus_if.pix_data  = val;
      tick();
      bus_if.pix_valid = 1'b0;
   endtask

   task automatic do_req();
      bus_if.word_req = 1'b1;
      tick();
      bus_if.word_req = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic skip_header();
      repeat (HL) do_req();
   endtask

   // Preload npre pixels base*(k+1), run one whole frame and check every word.
   task automatic run_frame(input int npre, input logic [15:0] base,
                            input int gap, input bit mid_fs, input string tag);
      logic [16:0] exp;
      for (int k = 0; k < npre; k++) push_px(16'(base * (k + 1)));
      pulse_fs();
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL %s_busy_start: got %b expected 1", tag, busy);
      else pass_cnt++;
      total_cnt++;
      if (underrun !== 1'b0) $display("FAIL %s_underrun_clear: got %b expected 0", tag, underrun);
      else pass_cnt++;
      for (int i = 0; i < HL + TOTAL; i++) begin
         if (i < HL)               exp = hdr_exp(i);
         else if (i - HL < npre)   exp = {1'b1, 16'(base * (i - HL + 1))};
         else                      exp = {1'b1, 16'h0000};
         total_cnt++;
         if ({bus_if.word_rs, bus_if.word_data} !== exp)
            $display("FAIL %s_word%0d: got rs=%b data=%h expected rs=%b data=%h",
                     tag, i, bus_if.word_rs, bus_if.word_data, exp[16], exp[15:0]);
         else pass_cnt++;
         if (mid_fs && i == HL + 2) begin
            pulse_fs();
            total_cnt++;
            if (busy !== 1'b1 || {bus_if.word_rs, bus_if.word_data} !== exp)
               $display("FAIL %s_fs_ignored: got busy=%b word=%h expected busy=1 word=%h",
                        tag, busy, {bus_if.word_rs, bus_if.word_data}, exp);
            else pass_cnt++;
         end
         do_req();
         if (i == HL + TOTAL - 1) begin
            total_cnt++;
            if (frame_done !== 1'b1 || busy !== 1'b0)
               $display("FAIL %s_done: got done=%b busy=%b expected done=1 busy=0",
                        tag, frame_done, busy);
            else pass_cnt++;
            total_cnt++;
            if ({bus_if.word_rs, bus_if.word_data} !== 17'h10000)
               $display("FAIL %s_idle_word: got %h expected 10000", tag,
                        {bus_if.word_rs, bus_if.word_data});
            else pass_cnt++;
            tick();
            total_cnt++;
            if (frame_done !== 1'b0) $display("FAIL %s_done_pulse: got %b expected 0", tag, frame_done);
            else pass_cnt++;
         end else begin
            total_cnt++;
            if (frame_done !== 1'b0) $display("FAIL %s_early_done%0d: got %b expected 0", tag, i, frame_done);
            else pass_cnt++;
            repeat (gap) tick();
         end
      end
      total_cnt++;
      if (underrun !== (npre < TOTAL))
         $display("FAIL %s_underrun_end: got %b expected %b", tag, underrun, (npre < TOTAL));
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      total_cnt++;
      if ({bus_if.word_rs, bus_if.word_data} !== 17'h10000 || busy !== 1'b0 ||
          frame_done !== 1'b0 || underrun !== 1'b0 || bus_if.pix_ready !== 1'b0)
         $display("FAIL reset_outputs: got word=%h busy=%b done=%b und=%b rdy=%b expected 10000 0 0 0 0",
                  {bus_if.word_rs, bus_if.word_data}, busy, frame_done, underrun, bus_if.pix_ready);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      total_cnt++;
      if (bus_if.pix_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus_if.pix_ready);
      else pass_cnt++;
      bus_if.word_req = 1'b1;
      repeat (2) tick();
      bus_if.word_req = 1'b0;
      total_cnt++;
      if ({bus_if.word_rs, bus_if.word_data} !== 17'h10000 || busy !== 1'b0)
         $display("FAIL idle_ignores_req: got word=%h busy=%b expected 10000 0",
                  {bus_if.word_rs, bus_if.word_data}, busy);
      else pass_cnt++;
   endtask

   task automatic test_full_frame();
      run_frame(8, 16'h1111, 1, 1'b0, "full");
   endtask

   task automatic test_underrun();
      run_frame(5, 16'h1111, 1, 1'b0, "short");
      run_frame(8, 16'h1111, 1, 1'b0, "clear");
   endtask

   task automatic test_mid_frame_start();
      run_frame(8, 16'h0101, 1, 1'b1, "midfs");
   endtask

   task automatic test_back_to_back();
      run_frame(8, 16'h1010, 0, 1'b0, "b2b");
   endtask

   task automatic test_fifo_full();
      for (int k = 0; k < DEPTH; k++) begin
         push_px(16'(16'hA001 + k));
         if (k == DEPTH - 2) begin
            total_cnt++;
            if (bus_if.pix_ready !== 1'b1) $display("FAIL ready_at_15: got %b expected 1", bus_if.pix_ready);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (bus_if.pix_ready !== 1'b0) $display("FAIL ready_at_16: got %b expected 0", bus_if.pix_ready);
      else pass_cnt++;
      push_px(16'hDEAD);
      total_cnt++;
      if (bus_if.pix_ready !== 1'b0) $display("FAIL ready_after_17th: got %b expected 0", bus_if.pix_ready);
      else pass_cnt++;
      pulse_fs();
      skip_header();
      total_cnt++;
      if ({bus_if.word_rs, bus_if.word_data} !== {1'b1, 16'hA001} || bus_if.pix_ready !== 1'b1)
         $display("FAIL full_first_pop: got word=%h rdy=%b expected 1a001 1",
                  {bus_if.word_rs, bus_if.word_data}, bus_if.pix_ready);
      else pass_cnt++;
      push_px(16'h1700);
      total_cnt++;
      if (bus_if.pix_ready !== 1'b0) $display("FAIL refill_full: got %b expected 0", bus_if.pix_ready);
      else pass_cnt++;
      // Pop and push together while full: only the pop takes effect.
      bus_if.pix_valid = 1'b1;
      bus_if.pix_data  = 16'hBEEF;
      do_req();
      bus_if.pix_valid = 1'b0;
      total_cnt++;
      if (bus_if.pix_ready !== 1'b1) $display("FAIL pop_push_full: got %b expected 1", bus_if.pix_ready);
      else pass_cnt++;
      for (int p = 1; p < TOTAL; p++) begin
         total_cnt++;
         if ({bus_if.word_rs, bus_if.word_data} !== {1'b1, 16'(16'hA001 + p)})
            $display("FAIL full_word%0d: got %h expected %h", p,
                     {bus_if.word_rs, bus_if.word_data}, {1'b1, 16'(16'hA001 + p)});
         else pass_cnt++;
         do_req();
      end
      total_cnt++;
      if (frame_done !== 1'b1) $display("FAIL full_done: got %b expected 1", frame_done);
      else pass_cnt++;
      tick();
      // Second frame drains the other eight preloaded pixels.
      pulse_fs();
      skip_header();
      for (int p = 0; p < TOTAL; p++) begin
         total_cnt++;
         if ({bus_if.word_rs, bus_if.word_data} !== {1'b1, 16'(16'hA009 + p)})
            $display("FAIL drain_word%0d: got %h expected %h", p,
                     {bus_if.word_rs, bus_if.word_data}, {1'b1, 16'(16'hA009 + p)});
         else pass_cnt++;
         do_req();
      end
      tick();
   endtask

   task automatic test_reset_mid_frame();
      pulse_fs();
      skip_header();
      // Only 0x1700 remains: 0xDEAD and 0xBEEF were offered while full.
      total_cnt++;
      if ({bus_if.word_rs, bus_if.word_data} !== {1'b1, 16'h1700})
         $display("FAIL leftover_pixel: got %h expected 11700", {bus_if.word_rs, bus_if.word_data});
      else pass_cnt++;
      do_req();
      total_cnt++;
      if ({bus_if.word_rs, bus_if.word_data} !== 17'h10000 || underrun !== 1'b1)
         $display("FAIL empty_underrun: got word=%h und=%b expected 10000 1",
                  {bus_if.word_rs, bus_if.word_data}, underrun);
      else pass_cnt++;
      do_req();
      do_req();
      push_px(16'h5555);
      push_px(16'h6666);
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus_if.word_rs, bus_if.word_data} !== 17'h10000 || busy !== 1'b0 ||
          frame_done !== 1'b0 || underrun !== 1'b0 || bus_if.pix_ready !== 1'b0)
         $display("FAIL abort_outputs: got word=%h busy=%b done=%b und=%b rdy=%b expected 10000 0 0 0 0",
                  {bus_if.word_rs, bus_if.word_data}, busy, frame_done, underrun, bus_if.pix_ready);
      else pass_cnt++;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total_cnt++;
         if (frame_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_no_done%0d: got done=%b busy=%b expected 0 0", c, frame_done, busy);
         else pass_cnt++;
      end
      // FIFO flushed by reset: the first pixel word underruns.
      pulse_fs();
      skip_header();
      total_cnt++;
      if ({bus_if.word_rs, bus_if.word_data} !== 17'h10000 || underrun !== 1'b1)
         $display("FAIL fifo_flushed: got word=%h und=%b expected 10000 1",
                  {bus_if.word_rs, bus_if.word_data}, underrun);
      else pass_cnt++;
      repeat (TOTAL) do_req();
      total_cnt++;
      if (frame_done !== 1'b1) $display("FAIL post_reset_done: got %b expected 1", frame_done);
      else pass_cnt++;
      tick();
   endtask

   initial begin
      rst_n            = 1'b0;
      frame_start      = 1'b0;
      bus_if.pix_valid = 1'b0;
      bus_if.pix_data  = 16'h0000;
      bus_if.word_req  = 1'b0;
      test_reset();
      test_full_frame();
      test_underrun();
      test_mid_frame_start();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
